dmem_copy_engine: RTL and testbench
===================================

# dmem_copy_engine

Bus-initiator block that drives the CPU's 128-entry, 32-bit word-addressed data memory (`addr`/`we`/`data` in, combinational `q` out) to copy a block of words from one address to another without CPU involvement. It sits beside the CPU on the data-memory port and owns that port only while `busy` is high; the port mux is outside this block. Overlapping regions are handled with memmove semantics.

## Interface
- `LEN_W`, default 8: width of the word-count input.
- `clk`  in  1  system clock, all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `src`  in  32  source word address, captured on accepted `start`.
- `dst`  in  32  destination word address, captured on accepted `start`.
- `len`  in  LEN_W  number of words, captured on accepted `start`.
- `busy`  out  1  high in READ/WRITE/FILL states.
- `done`  out  1  one-cycle completion pulse.
- `mem_addr`  out  32  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_data`  out  32  memory write data.
- `mem_q`  in  32  memory read data, valid in the same cycle as `mem_addr`.
- `fill`, `fill_value` (1, 32): present only with the configuration macro.

## Operation
- Reset: state IDLE; `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, all internal pointers and buffer 0.
- States: IDLE, READ, WRITE, FILL (macro only), DONE.
- IDLE: `start`=1 captures `src`, `dst`, `len`; `len`=0 -> DONE; else READ (or FILL).
- Direction: `dst` > `src` (unsigned) -> descending; pointers start at `src+len-1`, `dst+len-1` and decrement. Otherwise ascending from `src`, `dst`, incrementing. Pointer arithmetic modulo 2^32; memory uses only low 7 bits, so a region crossing entry 127 wraps to 0.
- READ: `mem_addr`=src pointer, `mem_we`=0; edge latches `mem_q` into buffer -> WRITE.
- WRITE: `mem_addr`=dst pointer, `mem_we`=1, `mem_data`=buffer; edge steps both pointers, decrements remaining count; count reaches 0 -> DONE, else READ.
- DONE: `done`=1, `busy`=0, `mem_we`=0 for one cycle -> IDLE.
- `start` outside IDLE ignored, not queued. `start` held high in DONE is ignored; it is re-sampled in the following IDLE cycle.
- Outputs decoded from state and pointer registers; in IDLE/DONE `mem_addr`=0, `mem_data`=0.

## Timing
- Start accepted at edge E0; first READ cycle follows E0.
- Copy of N>0 words: 2 cycles per word; `done` high in cycle 2N+1 after E0; `busy` high cycles 1..2N.
- N=0: `done` high in cycle 1, `busy` never high, no memory write.
- Back-to-back: earliest new `start` accepted in the IDLE cycle after `done`.
- Reset mid-operation: outputs return to reset values immediately (asynchronous); words already written remain; no `done`.

## Configuration
- `DMEM_COPY_FILL_EN` defined: ports `fill`, `fill_value` exist; `start` with `fill`=1 captures `fill_value`, ignores `src`, enters FILL: `mem_addr`=dst pointer, `mem_we`=1, `mem_data`=`fill_value`, one cycle per word, always ascending; `done` in cycle N+1.
- Not defined: ports and FILL state absent; every request is a copy.

## Test plan
- Memory model 0..127 = index; start src=0, dst=64, len=4 -> words 64..67 = 0,1,2,3; `done` in cycle 9; `busy` high exactly 8 cycles.
- Overlap forward: src=10, dst=12, len=4 (mem[i]=i) -> mem[12..15]=10,11,12,13; write order 15,14,13,12.
- Overlap backward: src=12, dst=10, len=4 -> mem[10..13]=12,13,14,15; write order ascending.
- len=0 -> `done` cycle 1, `mem_we` never high; `start` pulsed during busy -> ignored, single `done`.
- Reset asserted during 3rd WRITE of len=8 copy -> `mem_we`, `busy` drop same cycle; exactly 2 destination words written; no `done`.
- With `DMEM_COPY_FILL_EN`: fill=1, dst=126, len=4, fill_value=32'hDEADBEEF -> entries 126,127,0,1 = DEADBEEF; `done` in cycle 5.

Source files
------------

// File: rtl/dmem_copy_engine.sv
// Data-memory block copy engine with memmove-safe direction selection.
// Optional constant-fill mode is built in when DMEM_COPY_FILL_EN is defined.
module dmem_copy_engine #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
`ifdef DMEM_COPY_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_data,
    input  logic [31:0]      mem_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
`ifdef DMEM_COPY_FILL_EN
        S_FILL,
`endif
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] cnt;
    logic             desc;

    logic [31:0] len_ext;
    logic        desc_in;
    logic        last;

    assign len_ext = 32'(len);
    // Copying upward must walk from the top so overlapping source words
    // are read before they are overwritten.
    assign desc_in = dst > src;
    assign last    = cnt == LEN_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nx = S_DONE;
                    end else begin
`ifdef DMEM_COPY_FILL_EN
                        state_nx = fill ? S_FILL : S_READ;
`else
                        state_nx = S_READ;
`endif
                    end
                end
            end
            S_READ: begin
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                state_nx = last ? S_DONE : S_READ;
            end
`ifdef DMEM_COPY_FILL_EN
            S_FILL: begin
                state_nx = last ? S_DONE : S_FILL;
            end
`endif
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            buf_q   <= '0;
            cnt     <= '0;
            desc    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt <= len;
`ifdef DMEM_COPY_FILL_EN
                        if (fill) begin
                            // Fill reuses the word buffer as its constant.
                            src_ptr <= '0;
                            dst_ptr <= dst;
                            buf_q   <= fill_value;
                            desc    <= 1'b0;
                        end else
`endif
                        begin
                            desc    <= desc_in;
                            src_ptr <= desc_in ? src + len_ext - 32'd1 : src;
                            dst_ptr <= desc_in ? dst + len_ext - 32'd1 : dst;
                        end
                    end
                end
                S_READ: begin
                    buf_q <= mem_q;
                end
                S_WRITE: begin
                    src_ptr <= desc ? src_ptr - 32'd1 : src_ptr + 32'd1;
                    dst_ptr <= desc ? dst_ptr - 32'd1 : dst_ptr + 32'd1;
                    cnt     <= cnt - LEN_W'(1);
                end
`ifdef DMEM_COPY_FILL_EN
                S_FILL: begin
                    dst_ptr <= dst_ptr + 32'd1;
                    cnt     <= cnt - LEN_W'(1);
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_data = '0;
        unique case (state)
            S_READ: begin
                busy     = 1'b1;
                mem_addr = src_ptr;
            end
            S_WRITE: begin
                busy     = 1'b1;
                mem_addr = dst_ptr;
                mem_we   = 1'b1;
                mem_data = buf_q;
            end
`ifdef DMEM_COPY_FILL_EN
            S_FILL: begin
                busy     = 1'b1;
                mem_addr = dst_ptr;
                mem_we   = 1'b1;
                mem_data = buf_q;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench for dmem_copy_engine against a 128-word memory model.
// Build with DMEM_COPY_FILL_EN defined to also exercise fill mode.
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_data;
    logic [31:0] mem_q;
`ifdef DMEM_COPY_FILL_EN
    logic        fill;
    logic [31:0] fill_value;
`endif

    dmem_copy_engine #(.LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
`ifdef DMEM_COPY_FILL_EN
        .fill       (fill),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_data   (mem_data),
        .mem_q      (mem_q)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    assign mem_q = mem[mem_addr[6:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[6:0]] <= mem_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;

    int          exp_wa[$];
    logic [31:0] exp_wd[$];
    int          exp_dc[$];
    int          exp_db[$];

    // Monitor: pops expected writes and completions as the DUT shows them.
    always @(negedge clk) begin
        int          ea;
        logic [31:0] ed;
        int          ec;
        int          eb;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (mem_we) begin
                n_chk++;
                if (exp_wa.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected addr=%0d data=%h required=none",
                             mem_addr[6:0], mem_data);
                end else begin
                    ea = exp_wa.pop_front();
                    ed = exp_wd.pop_front();
                    if (int'(mem_addr[6:0]) != ea || mem_data !== ed) begin
                        n_fail++;
                        $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                                 mem_addr[6:0], mem_data, ea, ed);
                    end
                end
            end
            if (done) begin
                n_chk++;
                if (exp_dc.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected cyc=%0d required=none", cyc);
                end else begin
                    ec = exp_dc.pop_front();
                    eb = exp_db.pop_front();
                    if (cyc != ec || busy_cnt != eb) begin
                        n_fail++;
                        $display("FAIL done cyc=%0d busy=%0d required cyc=%0d busy=%0d",
                                 cyc, busy_cnt, ec, eb);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (exp_dc.size() == 0) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL done_timeout pending=%0d required=0", exp_dc.size());
        exp_dc.delete();
        exp_db.delete();
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d,
                         input logic [7:0] n, input bit f, input logic [31:0] fv);
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = n;
`ifdef DMEM_COPY_FILL_EN
        fill       = f;
        fill_value = fv;
`endif
        start = 1'b1;
        if (n == 0) begin
            exp_dc.push_back(cyc + 1);
            exp_db.push_back(0);
        end else if (f) begin
            exp_dc.push_back(cyc + int'(n) + 1);
            exp_db.push_back(int'(n));
        end else begin
            exp_dc.push_back(cyc + 2 * int'(n) + 1);
            exp_db.push_back(2 * int'(n));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
`ifdef DMEM_COPY_FILL_EN
        fill       = 1'b0;
        fill_value = '0;
`endif
        init_mem();
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        reset = 1'b0;

        // Non-overlapping upward copy, written top-down.
        push_wr(67, 3); push_wr(66, 2); push_wr(65, 1); push_wr(64, 0);
        issue(0, 64, 4, 1'b0, 0);
        wait_done();
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[64 + i], 32'(i));

        // Overlap, destination above source.
        init_mem();
        push_wr(15, 13); push_wr(14, 12); push_wr(13, 11); push_wr(12, 10);
        issue(10, 12, 4, 1'b0, 0);
        wait_done();
        for (int i = 0; i < 4; i++) chk("fwd_mem", mem[12 + i], 32'(10 + i));

        // Overlap, destination below source.
        init_mem();
        push_wr(10, 12); push_wr(11, 13); push_wr(12, 14); push_wr(13, 15);
        issue(12, 10, 4, 1'b0, 0);
        wait_done();
        for (int i = 0; i < 4; i++) chk("bwd_mem", mem[10 + i], 32'(12 + i));

        // Source region wraps past entry 127.
        init_mem();
        push_wr(2, 126); push_wr(3, 127); push_wr(4, 0);
        issue(126, 2, 3, 1'b0, 0);
        wait_done();
        chk("wrap_m2", mem[2], 32'd126);
        chk("wrap_m3", mem[3], 32'd127);
        chk("wrap_m4", mem[4], 32'd0);

        // Zero length completes at once without writing.
        issue(5, 9, 0, 1'b0, 0);
        wait_done();

        // Start pulsed mid-copy must be ignored.
        init_mem();
        push_wr(41, 21); push_wr(40, 20);
        issue(20, 40, 2, 1'b0, 0);
        @(negedge clk);
        src   = 0;
        dst   = 100;
        len   = 5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("ignored_m100", mem[100], 32'd100);

        // Start held through DONE is taken again in the next IDLE cycle.
        init_mem();
        push_wr(30, 20); push_wr(30, 20);
        @(negedge clk);
        src   = 20;
        dst   = 30;
        len   = 1;
        start = 1'b1;
        k = cyc;
        exp_dc.push_back(k + 3); exp_db.push_back(2);
        exp_dc.push_back(k + 7); exp_db.push_back(2);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        chk("held_m30", mem[30], 32'd20);

        // Reset during the third write of an 8-word copy.
        init_mem();
        push_wr(71, 7); push_wr(70, 6);
        @(negedge clk);
        src   = 0;
        dst   = 64;
        len   = 8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_wr_left", 32'(exp_wa.size()), 32'd0);
        chk("rst_m71", mem[71], 32'd7);
        chk("rst_m70", mem[70], 32'd6);
        chk("rst_m69", mem[69], 32'd69);

`ifdef DMEM_COPY_FILL_EN
        init_mem();
        push_wr(126, 32'hDEADBEEF); push_wr(127, 32'hDEADBEEF);
        push_wr(0, 32'hDEADBEEF);   push_wr(1, 32'hDEADBEEF);
        issue(50, 126, 4, 1'b1, 32'hDEADBEEF);
        wait_done();
        chk("fill_m126", mem[126], 32'hDEADBEEF);
        chk("fill_m127", mem[127], 32'hDEADBEEF);
        chk("fill_m0", mem[0], 32'hDEADBEEF);
        chk("fill_m1", mem[1], 32'hDEADBEEF);
        chk("fill_m2", mem[2], 32'd2);
`endif

        repeat (4) @(negedge clk);
        chk("wr_queue_empty", 32'(exp_wa.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_dc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
